parking_controller: RTL and testbench

PARKING_CONTROLLER -- requirements
Module: parking_controller

---
 rtl/parking_controller.sv | 138 +++++++++++++
 tb/tb_parking_controller.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_controller.sv
// Four-slot parking gate controller: grants entries/exits, times the gate, tracks occupancy.
// Optional macro PARKING_ALARM_EN adds a sticky alarm output for exits from empty slots.
module parking_controller #(
    parameter int unsigned GATE_CYCLES = 500
) (
    input  logic       clk_500Hz,
    input  logic       reset,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic [1:0] exit_slot,
    output logic [3:0] occupied,
    output logic [2:0] capacity,
    output logic [1:0] first_empty,
    output logic       gate_open,
    output logic       entry_ack,
    output logic       exit_ack,
    output logic [1:0] entry_slot,
    output logic       reject
`ifdef PARKING_ALARM_EN
    ,
    output logic       alarm
`endif
);

    localparam int unsigned TW = 10;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        GATE,
        WAIT_REL
    } state_t;

    state_t        state_q;
    logic [3:0]    occupied_q;
    logic [TW-1:0] timer_q;
    logic          gate_q;
    logic          entry_ack_q;
    logic          exit_ack_q;
    logic          reject_q;
    logic [1:0]    entry_slot_q;
`ifdef PARKING_ALARM_EN
    logic          alarm_q;
`endif

    logic [2:0] capacity_c;
    logic [1:0] first_empty_c;
    logic       exit_ok;
    logic       entry_ok;

    always_comb begin
        capacity_c = 3'd4 - (3'(occupied_q[0]) + 3'(occupied_q[1])
                           + 3'(occupied_q[2]) + 3'(occupied_q[3]));
        first_empty_c = 2'd0;
        for (int unsigned i = 4; i > 0; i--) begin
            if (!occupied_q[i-1]) begin
                first_empty_c = 2'(i - 1);
            end
        end
    end

    assign exit_ok  = exit_req && occupied_q[exit_slot];
    assign entry_ok = entry_req && (capacity_c != 3'd0);

    always_ff @(posedge clk_500Hz) begin
        if (reset) begin
            state_q      <= IDLE;
            occupied_q   <= '0;
            timer_q      <= '0;
            gate_q       <= 1'b0;
            entry_ack_q  <= 1'b0;
            exit_ack_q   <= 1'b0;
            reject_q     <= 1'b0;
            entry_slot_q <= '0;
`ifdef PARKING_ALARM_EN
            alarm_q      <= 1'b0;
`endif
        end else begin
            entry_ack_q <= 1'b0;
            exit_ack_q  <= 1'b0;
            reject_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Exit has priority; a held entry is re-evaluated when IDLE returns.
                    if (exit_ok) begin
                        occupied_q[exit_slot] <= 1'b0;
                        exit_ack_q            <= 1'b1;
                        gate_q                <= 1'b1;
                        timer_q               <= TIMER_LOAD;
                        state_q               <= GATE;
                    end else if (entry_ok) begin
                        occupied_q[first_empty_c] <= 1'b1;
                        entry_slot_q              <= first_empty_c;
                        entry_ack_q               <= 1'b1;
                        gate_q                    <= 1'b1;
                        timer_q                   <= TIMER_LOAD;
                        state_q                   <= GATE;
                    end else if (entry_req || exit_req) begin
                        reject_q <= 1'b1;
                        state_q  <= WAIT_REL;
`ifdef PARKING_ALARM_EN
                        if (exit_req) begin
                            alarm_q <= 1'b1;
                        end
`endif
                    end
                end
                GATE: begin
                    if (timer_q == '0) begin
                        gate_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                WAIT_REL: begin
                    if (!entry_req && !exit_req) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign occupied    = occupied_q;
    assign capacity    = capacity_c;
    assign first_empty = first_empty_c;
    assign gate_open   = gate_q;
    assign entry_ack   = entry_ack_q;
    assign exit_ack    = exit_ack_q;
    assign entry_slot  = entry_slot_q;
    assign reject      = reject_q;
`ifdef PARKING_ALARM_EN
    assign alarm       = alarm_q;
`endif

endmodule

// File: tb/tb_parking_controller.sv
// Directed bench for parking_controller with a cycle-level behavioural model and per-cycle compare.
module tb_parking_controller;

    localparam int unsigned GC = 500;

    logic       clk_500Hz = 1'b0;
    logic       reset     = 1'b1;
    logic       entry_req = 1'b0;
    logic       exit_req  = 1'b0;
    logic [1:0] exit_slot = 2'd0;
    logic [3:0] occupied;
    logic [2:0] capacity;
    logic [1:0] first_empty;
    logic       gate_open;
    logic       entry_ack;
    logic       exit_ack;
    logic [1:0] entry_slot;
    logic       reject;
`ifdef PARKING_ALARM_EN
    logic       alarm;
`endif

    parking_controller #(.GATE_CYCLES(GC)) dut (
        .clk_500Hz   (clk_500Hz),
        .reset       (reset),
        .entry_req   (entry_req),
        .exit_req    (exit_req),
        .exit_slot   (exit_slot),
        .occupied    (occupied),
        .capacity    (capacity),
        .first_empty (first_empty),
        .gate_open   (gate_open),
        .entry_ack   (entry_ack),
        .exit_ack    (exit_ack),
        .entry_slot  (entry_slot),
        .reject      (reject)
`ifdef PARKING_ALARM_EN
        ,
        .alarm       (alarm)
`endif
    );

    always #5 clk_500Hz = ~clk_500Hz;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: occupancy as a bitmask, gate as cycles still to stay open, a release-wait flag.
    logic [3:0] m_occ = 4'd0;
    int         m_gate_left = 0;
    bit         m_hold = 0;
    bit         m_eack = 0, m_xack = 0, m_rej = 0, m_rst = 0;
    logic [1:0] m_slot = 2'd0;
    bit         m_alarm = 0;
    bit         m_valid = 0;

    function automatic int free_of(input logic [3:0] o);
        int n = 0;
        for (int i = 0; i < 4; i++) if (!o[i]) n++;
        return n;
    endfunction

    function automatic logic [1:0] lowest_free(input logic [3:0] o);
        for (int i = 0; i < 4; i++) if (!o[i]) return 2'(i);
        return 2'd0;
    endfunction

    initial forever begin
        @(posedge clk_500Hz);
        m_eack = 0; m_xack = 0; m_rej = 0; m_rst = 0;
        if (reset) begin
            m_occ = 4'd0; m_gate_left = 0; m_hold = 0; m_slot = 2'd0;
            m_alarm = 0; m_valid = 1; m_rst = 1;
        end else if (!m_valid) begin
            m_rst = 0;
        end else if (m_gate_left > 0) begin
            m_gate_left--;
        end else if (m_hold) begin
            if (!entry_req && !exit_req) m_hold = 0;
        end else if (exit_req && m_occ[exit_slot]) begin
            m_occ[exit_slot] = 1'b0;
            m_xack = 1; m_gate_left = GC;
        end else if (entry_req && free_of(m_occ) > 0) begin
            m_slot = lowest_free(m_occ);
            m_occ[m_slot] = 1'b1;
            m_eack = 1; m_gate_left = GC;
        end else if (entry_req || exit_req) begin
            m_rej = 1; m_hold = 1;
            if (exit_req) m_alarm = 1;
        end
    end

    initial forever begin
        @(negedge clk_500Hz);
        if (m_valid) begin
            check("occupied", occupied, m_occ);
            check("capacity", capacity, free_of(m_occ));
            check("first_empty", first_empty, lowest_free(m_occ));
            check("gate_open", gate_open, m_gate_left > 0);
            check("entry_ack", entry_ack, m_eack);
            check("exit_ack", exit_ack, m_xack);
            check("reject", reject, m_rej);
            if (m_eack || m_rst) check("entry_slot", entry_slot, m_slot);
`ifdef PARKING_ALARM_EN
            check("alarm", alarm, m_alarm);
`endif
        end
    end

    task automatic tick();
        @(posedge clk_500Hz);
        #1;
    endtask

    // which: 0 entry_ack, 1 exit_ack, 2 reject
    task automatic wait_pulse(input int which, input int budget, input string name);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_500Hz);
            if ((which == 0 && entry_ack === 1'b1) || (which == 1 && exit_ack === 1'b1) ||
                (which == 2 && reject === 1'b1)) begin
                ok = 1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: pulse not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_gate_closed(input string name, output int high);
        high = 0;
        while (gate_open === 1'b1 && high < 2 * GC) begin
            high++;
            @(negedge clk_500Hz);
        end
        n_cmp++;
        if (gate_open !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: gate_open still %b after %0d cycles", name, gate_open, high);
        end
    endtask

    initial begin
        int hi;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk_500Hz);
        check("rst_capacity", capacity, 4);
        check("rst_first_empty", first_empty, 0);
        check("rst_occupied", occupied, 0);
        check("rst_gate", gate_open, 0);

        // First entry: slot 0, gate open for exactly GC cycles.
        entry_req = 1'b1;
        wait_pulse(0, 8, "entry0_ack");
        entry_req = 1'b0;
        check("entry0_slot", entry_slot, 0);
        wait_gate_closed("entry0_gate", hi);
        check("entry0_gate_len", hi, 500);
        check("entry0_capacity", capacity, 3);
        check("entry0_first_empty", first_empty, 1);

        for (int s = 1; s < 4; s++) begin
            entry_req = 1'b1;
            wait_pulse(0, 8, "seq_entry_ack");
            entry_req = 1'b0;
            check("seq_entry_slot", entry_slot, s);
            wait_gate_closed("seq_gate", hi);
        end

        // Lot full: fifth entry refused, controller holds until the request drops.
        entry_req = 1'b1;
        wait_pulse(2, 8, "full_reject");
        check("full_capacity", capacity, 0);
        check("full_first_empty", first_empty, 0);
        repeat (6) begin
            @(negedge clk_500Hz);
            check("waitrel_no_reject", reject, 0);
            check("waitrel_no_ack", entry_ack, 0);
        end
        entry_req = 1'b0;
        @(negedge clk_500Hz);

        // Simultaneous entry and exit of slot 2: exit first, entry later takes slot 2.
        entry_req = 1'b1;
        exit_req  = 1'b1;
        exit_slot = 2'd2;
        wait_pulse(1, 8, "both_exit_ack");
        exit_req = 1'b0;
        check("both_no_entry_ack", entry_ack, 0);
        check("both_occupied", occupied, 4'b1011);
        wait_gate_closed("both_exit_gate", hi);
        check("both_exit_gate_len", hi, 500);
        wait_pulse(0, 4, "pending_entry_ack");
        entry_req = 1'b0;
        check("pending_entry_slot", entry_slot, 2);
        @(negedge clk_500Hz);
        check("pending_capacity", capacity, 0);
        wait_gate_closed("pending_gate", hi);

        // Exit from an empty slot is refused and occupancy is untouched.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        entry_req = 1'b1;
        wait_pulse(0, 8, "one_entry_ack");
        entry_req = 1'b0;
        wait_gate_closed("one_gate", hi);
        exit_req  = 1'b1;
        exit_slot = 2'd3;
        wait_pulse(2, 8, "bad_exit_reject");
        check("bad_exit_occupied", occupied, 4'b0001);
`ifdef PARKING_ALARM_EN
        check("alarm_set", alarm, 1);
`endif
        exit_req = 1'b0;
        repeat (3) @(negedge clk_500Hz);
`ifdef PARKING_ALARM_EN
        check("alarm_held", alarm, 1);
`endif

        // Invalid exit with a grantable entry: entry wins, held exit refused afterwards.
        exit_req  = 1'b1;
        exit_slot = 2'd3;
        entry_req = 1'b1;
        wait_pulse(0, 8, "entry_over_bad_exit");
        entry_req = 1'b0;
        check("entry_over_bad_exit_slot", entry_slot, 1);
        wait_pulse(2, GC + 10, "deferred_reject");
        exit_req = 1'b0;
        repeat (2) @(negedge clk_500Hz);

        // Exit request raised mid-gate is deferred until the gate closes.
        entry_req = 1'b1;
        wait_pulse(0, 8, "gate_entry_ack");
        entry_req = 1'b0;
        check("gate_entry_slot", entry_slot, 2);
        repeat (10) @(negedge clk_500Hz);
        exit_req  = 1'b1;
        exit_slot = 2'd0;
        wait_pulse(1, GC + 10, "deferred_exit_ack");
        exit_req = 1'b0;
        check("deferred_exit_occupied", occupied, 4'b0110);
        wait_gate_closed("deferred_exit_gate", hi);

        // Reset 100 cycles into a gate cycle closes the gate and clears the lot.
        entry_req = 1'b1;
        wait_pulse(0, 8, "pre_reset_entry_ack");
        entry_req = 1'b0;
        repeat (100) @(negedge clk_500Hz);
        check("mid_gate_open", gate_open, 1);
        reset = 1'b1;
        @(negedge clk_500Hz);
        check("rst_mid_gate", gate_open, 0);
        check("rst_mid_occupied", occupied, 0);
        check("rst_mid_capacity", capacity, 4);
`ifdef PARKING_ALARM_EN
        check("rst_mid_alarm", alarm, 0);
`endif
        reset = 1'b0;
        repeat (4) @(negedge clk_500Hz);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
